// File: rtl/system_types_pkg.sv
// Shared types and sizing for the instruction-fetch front end.
package system_types_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;
   localparam int DEPTH   = 2;

   typedef logic signed [PC_W-1:0] pc_t;
   typedef logic [INSTR_W-1:0]     instr_t;

   // Tag remembered for every accepted fetch request.
   typedef struct packed {
      pc_t  pc;
      logic epoch;
   } fetch_tag_t;

   // Entry held in the instruction buffer for decode.
   typedef struct packed {
      instr_t instr;
      pc_t    pc;
   } dec_entry_t;

   localparam int TAG_W   = $bits(fetch_tag_t);
   localparam int ENTRY_W = $bits(dec_entry_t);

endpackage

// File: rtl/system_fetch_fifo.sv
// Two-entry synchronous FIFO with flush. The head entry is read straight
// out of a register, so data_o is a registered output.
module system_fetch_fifo #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         empty_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] mem_q [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push, do_pop;

   assign empty_o = (count_q == 2'd0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & ((count_q != 2'd2) | do_pop);

   // Next pointers and occupancy; flush returns the FIFO to empty.
   always_comb begin
      // NOTE: defaults first so every path assigns each signal and no latch is inferred.
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) wr_ptr_d = ~wr_ptr_q;
         if (do_pop)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   // Pointer, occupancy and storage registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: storage is reset because the head entry drives outputs that must read zero out of reset.
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/system_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order fetches under a
// shared credit limit, and buffers returned words for decode. A 1-bit epoch
// discards responses that were in flight when a redirect happened.
// Optional macro SYSTEM_FETCH_DROPCNT_EN adds drop_cnt, a saturating count of
// epoch-mismatched responses.
module system_fetch_unit
   import system_types_pkg::*;
(
   input  logic               system1000,
   input  logic               system1000_rst,
   input  logic               redir_valid,
   input  logic [PC_W-1:0]    redir_pc,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [PC_W-1:0]    imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [PC_W-1:0]    dec_pc
`ifdef SYSTEM_FETCH_DROPCNT_EN
   ,
   output logic [7:0]         drop_cnt
`endif
);

   pc_t        pc_q, pc_d;
   logic       epoch_q, epoch_d;
   fetch_tag_t tag_in, tag_head;
   dec_entry_t buf_in, buf_head;
   logic [1:0] tag_cnt, buf_cnt;
   logic [2:0] occupancy;
   logic       tag_empty, buf_empty;
   logic       req_fire, rsp_fire, tag_match, buf_push, dec_fire;

   // Outstanding requests plus buffered words share one credit pool.
   assign occupancy      = {1'b0, tag_cnt} + {1'b0, buf_cnt};
   assign imem_req_valid = (occupancy < 3'(DEPTH)) & ~system1000_rst;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // A response with no tag outstanding is a protocol error and is ignored.
   assign rsp_fire  = imem_rsp_valid & ~tag_empty;
   assign tag_match = (tag_head.epoch == epoch_q);
   assign buf_push  = rsp_fire & tag_match & ~redir_valid;
   assign dec_fire  = dec_valid & dec_ready;

   assign tag_in = '{pc: pc_q, epoch: epoch_q};
   assign buf_in = '{instr: imem_rsp_data, pc: tag_head.pc};

   assign dec_valid = ~buf_empty;
   assign dec_instr = buf_head.instr;
   assign dec_pc    = buf_head.pc;

   // Tags of accepted requests; never flushed, drained only by responses.
   system_fetch_fifo #(.W(TAG_W)) u_tag_fifo (
      .clk_i   (system1000),
      .rst_i   (system1000_rst),
      .push_i  (req_fire),
      .pop_i   (rsp_fire),
      .flush_i (1'b0),
      .data_i  (tag_in),
      .data_o  (tag_head),
      .empty_o (tag_empty),
      .count_o (tag_cnt)
   );

   // Instruction buffer toward decode; a redirect flushes it.
   system_fetch_fifo #(.W(ENTRY_W)) u_instr_buf (
      .clk_i   (system1000),
      .rst_i   (system1000_rst),
      .push_i  (buf_push),
      .pop_i   (dec_fire),
      .flush_i (redir_valid),
      .data_i  (buf_in),
      .data_o  (buf_head),
      .empty_o (buf_empty),
      .count_o (buf_cnt)
   );

   // Next PC and epoch: a redirect wins over sequential increment.
   always_comb begin
      pc_d    = pc_q;
      epoch_d = epoch_q;
      if (redir_valid) begin
         pc_d    = redir_pc;
         epoch_d = ~epoch_q;
      end else if (req_fire) begin
         pc_d = pc_q + pc_t'(1);
      end
   end

   // PC and epoch registers.
   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         pc_q    <= '0;
         epoch_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         epoch_q <= epoch_d;
      end
   end

`ifdef SYSTEM_FETCH_DROPCNT_EN
   logic [7:0] drop_q, drop_d;

   assign drop_cnt = drop_q;

   // Saturating count of responses discarded for a stale epoch.
   always_comb begin
      drop_d = drop_q;
      if (rsp_fire && !tag_match && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
   end

   // Drop counter register.
   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) drop_q <= 8'd0;
      else                drop_q <= drop_d;
   end
`endif

endmodule

// File: tb/tb_system_fetch_unit.sv
// Self-checking bench for system_fetch_unit: a queue-based reference model
// and a memory model with configurable latency drive per-cycle comparisons,
// and each scenario task also checks its own outcome.
module tb_system_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redir_valid = 1'b0;
   logic [7:0]  redir_pc = 8'h00;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [7:0]  req_addr;
   logic        rsp_valid = 1'b0;
   logic [15:0] rsp_data = 16'h0000;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [15:0] dec_instr;
   logic [7:0]  dec_pc;
`ifdef SYSTEM_FETCH_DROPCNT_EN
   logic [7:0]  drop_cnt;
`endif

   system_fetch_unit dut (
      .system1000     (clk),
      .system1000_rst (rst),
      .redir_valid    (redir_valid),
      .redir_pc       (redir_pc),
      .imem_req_valid (req_valid),
      .imem_req_ready (req_ready),
      .imem_req_addr  (req_addr),
      .imem_rsp_valid (rsp_valid),
      .imem_rsp_data  (rsp_data),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc)
`ifdef SYSTEM_FETCH_DROPCNT_EN
      ,
      .drop_cnt       (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] pc; bit ep; } tag_m_t;
   typedef struct { logic [15:0] instr; logic [7:0] pc; } ent_m_t;
   typedef struct { logic [7:0] addr; logic [15:0] data; int due; } mem_m_t;

   // Reference model state.
   tag_m_t     tagq[$];
   ent_m_t     bufq[$];
   logic [7:0] pc_m;
   bit         ep_m;
   int         drop_m;

   // Memory model and observation logs.
   mem_m_t     memq[$];
   logic [7:0] obs_acc[$];
   ent_m_t     obs_dec[$];
   int         cyc = 0;
   int         lat = 1;
   int         last_due = 0;
   bit         rand_data = 1'b0;

   int checks = 0;
   int errors = 0;

   function automatic bit model_req_valid();
      return !rst && (tagq.size() + bufq.size() < 2);
   endfunction

   task automatic model_clear();
      tagq.delete();
      bufq.delete();
      pc_m   = 8'h00;
      ep_m   = 1'b0;
      drop_m = 0;
   endtask

   // One clock cycle: drive the memory response, compare all outputs with the
   // model, log observed handshakes, then advance the model at the edge.
   task automatic cycle();
      bit         exp_rv, acc, xfer, have;
      tag_m_t     t;
      logic [15:0] d;
      rsp_valid = (memq.size() > 0) && (memq[0].due <= cyc);
      rsp_data  = rsp_valid ? memq[0].data : 16'($urandom);
      #1;
      exp_rv = model_req_valid();
      checks++;
      if (req_valid !== exp_rv) begin
         errors++;
         $display("FAIL req_valid cyc=%0d got %b expected %b", cyc, req_valid, exp_rv);
      end
      checks++;
      if (req_addr !== pc_m) begin
         errors++;
         $display("FAIL req_addr cyc=%0d got %h expected %h", cyc, req_addr, pc_m);
      end
      checks++;
      if (dec_valid !== (bufq.size() > 0)) begin
         errors++;
         $display("FAIL dec_valid cyc=%0d got %b expected %b", cyc, dec_valid, bufq.size() > 0);
      end
      if (bufq.size() > 0) begin
         checks++;
         if (dec_instr !== bufq[0].instr || dec_pc !== bufq[0].pc) begin
            errors++;
            $display("FAIL dec_data cyc=%0d got %h@%h expected %h@%h", cyc,
                     dec_instr, dec_pc, bufq[0].instr, bufq[0].pc);
         end
      end
`ifdef SYSTEM_FETCH_DROPCNT_EN
      checks++;
      if (drop_cnt !== 8'(drop_m)) begin
         errors++;
         $display("FAIL drop_cnt cyc=%0d got %0d expected %0d", cyc, drop_cnt, drop_m);
      end
`endif
      if (req_valid === 1'b1 && req_ready) begin
         obs_acc.push_back(req_addr);
         d = rand_data ? 16'($urandom) : 16'h1000 + {8'h00, req_addr};
         last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         memq.push_back('{addr: req_addr, data: d, due: last_due});
      end
      if (dec_valid === 1'b1 && dec_ready) obs_dec.push_back('{instr: dec_instr, pc: dec_pc});
      @(posedge clk);
      if (rst) begin
         model_clear();
      end else begin
         acc  = exp_rv && req_ready;
         xfer = (bufq.size() > 0) && dec_ready;
         have = 1'b0;
         if (rsp_valid && tagq.size() > 0) begin
            t    = tagq.pop_front();
            have = 1'b1;
         end
         if (xfer) void'(bufq.pop_front());
         if (have) begin
            if (t.ep != ep_m) begin
               if (drop_m < 255) drop_m++;
            end else if (!redir_valid) begin
               bufq.push_back('{instr: rsp_data, pc: t.pc});
            end
         end
         if (acc) tagq.push_back('{pc: pc_m, ep: ep_m});
         if (redir_valid) begin
            bufq.delete();
            pc_m = redir_pc;
            ep_m = ~ep_m;
         end else if (acc) begin
            pc_m = pc_m + 8'd1;
         end
      end
      if (rsp_valid) void'(memq.pop_front());
      cyc++;
      @(negedge clk);
   endtask

   // Clean restart: reset for one cycle with the memory pipeline emptied.
   task automatic fresh();
      rst = 1'b1;
      redir_valid = 1'b0;
      memq.delete();
      model_clear();
      cycle();
      rst = 1'b0;
      obs_acc.delete();
      obs_dec.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      model_clear();
      checks++;
      if (req_valid !== 1'b0 || req_addr !== 8'h00 || dec_valid !== 1'b0 ||
          dec_instr !== 16'h0000 || dec_pc !== 8'h00) begin
         errors++;
         $display("FAIL reset_values got rv=%b addr=%h dv=%b instr=%h pc=%h expected all zero",
                  req_valid, req_addr, dec_valid, dec_instr, dec_pc);
      end
`ifdef SYSTEM_FETCH_DROPCNT_EN
      checks++;
      if (drop_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_drop_cnt got %0d expected 0", drop_cnt);
      end
`endif
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      fresh();
      lat = 1;
      rand_data = 1'b0;
      req_ready = 1'b1;
      dec_ready = 1'b1;
      repeat (14) cycle();
      checks++;
      if (obs_dec.size() < 4) begin
         errors++;
         $display("FAIL seq_count got %0d expected at least 4", obs_dec.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_dec[i].pc !== 8'(i) || obs_dec[i].instr !== 16'h1000 + 16'(i)) begin
               errors++;
               $display("FAIL seq_%0d got %h@%h expected %h@%h", i, obs_dec[i].instr,
                        obs_dec[i].pc, 16'h1000 + 16'(i), 8'(i));
            end
         end
      end
   endtask

   task automatic test_credits();
      fresh();
      lat = 1;
      req_ready = 1'b1;
      dec_ready = 1'b0;
      repeat (10) cycle();
      checks++;
      if (obs_acc.size() != 2 || req_valid !== 1'b0) begin
         errors++;
         $display("FAIL credit_stall got %0d requests rv=%b expected 2 requests rv=0",
                  obs_acc.size(), req_valid);
      end else begin
         checks++;
         if (obs_acc[0] !== 8'h00 || obs_acc[1] !== 8'h01) begin
            errors++;
            $display("FAIL credit_addrs got %h,%h expected 00,01", obs_acc[0], obs_acc[1]);
         end
      end
      dec_ready = 1'b1;
      repeat (8) cycle();
      checks++;
      if (obs_dec.size() < 2 || obs_acc.size() < 3) begin
         errors++;
         $display("FAIL credit_release got %0d decodes %0d requests expected >=2 and >=3",
                  obs_dec.size(), obs_acc.size());
      end else begin
         checks++;
         if (obs_dec[0].pc !== 8'h00 || obs_dec[1].pc !== 8'h01 || obs_acc[2] !== 8'h02) begin
            errors++;
            $display("FAIL credit_resume got pcs %h,%h next req %h expected 00,01 next 02",
                     obs_dec[0].pc, obs_dec[1].pc, obs_acc[2]);
         end
      end
   endtask

   task automatic test_redirect_inflight();
      fresh();
      lat = 3;
      rand_data = 1'b0;
      req_ready = 1'b1;
      dec_ready = 1'b1;
      cycle();
      cycle();
      checks++;
      if (obs_acc.size() != 2) begin
         errors++;
         $display("FAIL inflight_reqs got %0d expected 2", obs_acc.size());
      end
      redir_valid = 1'b1;
      redir_pc = 8'h40;
      cycle();
      redir_valid = 1'b0;
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_dec_valid got %b expected 0", dec_valid);
      end
      repeat (14) cycle();
      checks++;
      if (obs_dec.size() == 0) begin
         errors++;
         $display("FAIL redir_target got no decode expected pc 40");
      end else if (obs_dec[0].pc !== 8'h40 || obs_dec[0].instr !== 16'h1040) begin
         errors++;
         $display("FAIL redir_target got %h@%h expected 1040@40", obs_dec[0].instr, obs_dec[0].pc);
      end
`ifdef SYSTEM_FETCH_DROPCNT_EN
      checks++;
      if (drop_cnt !== 8'd2) begin
         errors++;
         $display("FAIL redir_drop_cnt got %0d expected 2", drop_cnt);
      end
`endif
   endtask

   task automatic test_redirect_accept();
      int n, m;
      bit found;
      fresh();
      lat = 1;
      rand_data = 1'b0;
      req_ready = 1'b1;
      dec_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (req_valid === 1'b1 && req_addr === 8'h05) found = 1'b1;
         else cycle();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL redir_acc_setup got no request at 05 expected one within 40 cycles");
      end else begin
         n = obs_acc.size();
         redir_valid = 1'b1;
         redir_pc = 8'hFD;
         cycle();
         redir_valid = 1'b0;
         m = obs_dec.size();
         checks++;
         if (obs_acc.size() != n + 1 || req_addr !== 8'hFD) begin
            errors++;
            $display("FAIL redir_acc_addr got %0d accepts addr %h expected %0d accepts addr fd",
                     obs_acc.size() - n, req_addr, 1);
         end
         repeat (12) cycle();
         checks++;
         if (obs_dec.size() <= m) begin
            errors++;
            $display("FAIL redir_acc_target got no decode expected pc fd");
         end else if (obs_dec[m].pc !== 8'hFD) begin
            errors++;
            $display("FAIL redir_acc_target got pc %h expected fd", obs_dec[m].pc);
         end
         for (int i = m; i < obs_dec.size(); i++) begin
            checks++;
            if (obs_dec[i].pc === 8'h05) begin
               errors++;
               $display("FAIL redir_acc_stale got pc 05 at decode %0d expected dropped", i);
            end
         end
      end
   endtask

   task automatic test_wrap();
      int k;
      fresh();
      lat = 1;
      rand_data = 1'b0;
      req_ready = 1'b1;
      dec_ready = 1'b1;
      redir_valid = 1'b1;
      redir_pc = 8'h7E;
      cycle();
      redir_valid = 1'b0;
      repeat (14) cycle();
      k = -1;
      for (int i = 0; i < obs_dec.size(); i++) if (k < 0 && obs_dec[i].pc === 8'h7F) k = i;
      checks++;
      if (k < 0 || k + 1 >= obs_dec.size()) begin
         errors++;
         $display("FAIL wrap_seq got no decode pair starting at 7f expected 7f then 80");
      end else if (obs_dec[k+1].pc !== 8'h80 || obs_dec[k+1].instr !== 16'h1080) begin
         errors++;
         $display("FAIL wrap_seq got %h@%h expected 1080@80", obs_dec[k+1].instr, obs_dec[k+1].pc);
      end
   endtask

   task automatic test_reset_midstream();
      fresh();
      lat = 3;
      rand_data = 1'b0;
      req_ready = 1'b1;
      dec_ready = 1'b1;
      cycle();
      cycle();
      rst = 1'b1;
      #1;
      model_clear();
      checks++;
      if (req_valid !== 1'b0 || req_addr !== 8'h00 || dec_valid !== 1'b0 ||
          dec_instr !== 16'h0000 || dec_pc !== 8'h00) begin
         errors++;
         $display("FAIL midreset_values got rv=%b addr=%h dv=%b instr=%h pc=%h expected all zero",
                  req_valid, req_addr, dec_valid, dec_instr, dec_pc);
      end
      @(negedge clk);
      req_ready = 1'b0;
      cycle();
      rst = 1'b0;
      obs_acc.delete();
      obs_dec.delete();
      repeat (5) cycle();
      checks++;
      if (obs_dec.size() != 0 || memq.size() != 0) begin
         errors++;
         $display("FAIL midreset_late got %0d decodes %0d pending expected 0 and 0",
                  obs_dec.size(), memq.size());
      end
      req_ready = 1'b1;
      repeat (10) cycle();
      checks++;
      if (obs_acc.size() == 0 || obs_dec.size() == 0) begin
         errors++;
         $display("FAIL midreset_restart got %0d requests %0d decodes expected some",
                  obs_acc.size(), obs_dec.size());
      end else if (obs_acc[0] !== 8'h00 || obs_dec[0].pc !== 8'h00 || obs_dec[0].instr !== 16'h1000) begin
         errors++;
         $display("FAIL midreset_restart got req %h decode %h@%h expected 00 and 1000@00",
                  obs_acc[0], obs_dec[0].instr, obs_dec[0].pc);
      end
   endtask

   task automatic test_random();
      fresh();
      rand_data = 1'b1;
      for (int i = 0; i < 800; i++) begin
         req_ready   = ($urandom_range(0, 3) != 0);
         dec_ready   = ($urandom_range(0, 3) != 0);
         redir_valid = ($urandom_range(0, 11) == 0);
         redir_pc    = 8'($urandom);
         lat         = $urandom_range(1, 3);
         cycle();
      end
      redir_valid = 1'b0;
      dec_ready   = 1'b1;
      repeat (10) cycle();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_credits();
      test_redirect_inflight();
      test_redirect_accept();
      test_wrap();
      test_reset_midstream();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
